fft_butterfly01: RTL and testbench
==================================

// Module: fft_butterfly01
// PURPOSE
//  16-lane radix-2 butterfly, stage 01 of the 512-point radix-2^2 FFT datapath.
//  - Per valid beat, takes 16 complex A samples and 16 complex B samples (10-bit).
//  - Produces the sum A+B, and the difference A-B with the trivial twiddle (1 or -j) applied.
//  - Outputs are sign-extended to 13 bits for the next stage.
// PARAMETERS
//  LANES      16  complex samples per beat, per operand
//  IN_W       10  signed input component width
//  OUT_W      13  signed output component width
//  IDX_W      9   point-index width (512 points)
// PORTS
//  clk             in   1           rising-edge clock, single clock domain
//  rstn            in   1           synchronous reset, ACTIVE-HIGH (1 = reset) despite name
//  valid_in        in   1           beat qualifier for all input arrays and base_input_idx
//  base_input_idx  in   IDX_W       global point index of lane 0 (multiple of 16)
//  input_real_a    in   IN_W x16    A real, lane i = point base+i
//  input_imag_a    in   IN_W x16    A imaginary
//  input_real_b    in   IN_W x16    B real
//  input_imag_b    in   IN_W x16    B imaginary
//  valid_out       out  1           result beat qualifier
//  output_real_a   out  OUT_W x16   sum real
//  output_imag_a   out  OUT_W x16   sum imaginary
//  output_real_b   out  OUT_W x16   rotated difference real
//  output_imag_b   out  OUT_W x16   rotated difference imaginary
// BEHAVIOUR
//  Reset:
//  - While rstn=1 at a clk edge: all outputs go to 0, valid_out=0.
//  - Both pipeline valid bits are cleared; in-flight beats are discarded and never emerge.
//  Pipeline (fully pipelined, no stall, no backpressure; one beat accepted every cycle):
//  - S1 (edge after valid_in=1): register per-lane sum s=a+b and diff d=a-b.
//    Each is 11-bit signed, computed sign-extended with no overflow.
//    Also register the rotate flag.
//  - S2: register outputs; valid_out=1 exactly 2 cycles after the accepting edge.
//  - valid_out is high for exactly one cycle per accepted beat.
//  - Order is preserved; back-to-back beats give back-to-back valid_out.
//  - When valid_out=0, data outputs hold their last value. Only valid_out is meaningful.
//  - valid_in=0: inputs ignored; nothing enters the pipe.
//  Twiddle, per lane i, n = (base_input_idx + i) mod 512:
//  - rotate = n[7], i.e. (n mod 256) >= 128.
//  - rotate=0: out_b = d  (real=d.re, imag=d.im).
//  - rotate=1: out_b = d * (-j)  (real = d.im, imag = -d.re).
//  - Because base_input_idx is a multiple of 16, all lanes share one rotate value.
//    The RTL still evaluates rotate per lane.
//  - The index wraps at 512 (9-bit add).
//  Arithmetic:
//  - All results are sign-extended to OUT_W. No saturation or rounding is needed.
//  - Ranges: |sum|,|d| <= 1024; -d.re in [-1023,1024] fits OUT_W.
//  - out_a = s (real, imag), no twiddle.
//  Simultaneous events: rstn=1 with valid_in=1 -> reset wins; the beat is dropped.
// TESTING
//  T1 reset: hold rstn=1 for 2 cycles with valid_in=1 -> valid_out=0; all outputs 0;
//     no valid_out afterwards.
//  T2 idx=0, all lanes a=100-j50, b=30+j20 -> 2 cycles later, one-cycle valid_out;
//     out_a=130-j30, out_b=70-j70.
//  T3 same data, idx=128 -> out_a=130-j30, out_b=-70-j70.
//     Also check idx=240 (rotated) and idx=256 (not rotated).
//  T4 extremes: a=511+j511, b=-512-j512.
//     idx=0   -> out_a=-1-j1, out_b=1023+j1023.
//     idx=384 -> out_b=1023-j1023, correctly sign-extended in 13 bits.
//  T5 streaming: valid_in high for 32 consecutive cycles, idx=0,16,...,496, ramp data
//     -> 32 contiguous valid_out cycles, in order, each matching the reference model.
//  T6 reset mid-flight: accept a beat, assert rstn on the next edge
//     -> no valid_out for that beat; next accepted beat has normal 2-cycle latency.

Source files
------------

// File: rtl/fft_butterfly01.sv
// rtl/fft_butterfly01.sv - 16-lane radix-2 butterfly, stage 01 of the 512-point radix-2^2 FFT
// Two-stage pipeline: S1 registers sum/difference, S2 applies the trivial twiddle and widens.
module fft_butterfly01 #(
  parameter int LANES = 16,
  parameter int IN_W  = 10,
  parameter int OUT_W = 13,
  parameter int IDX_W = 9
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            valid_in,
  input  logic [IDX_W-1:0]                base_input_idx,
  input  logic [LANES-1:0][IN_W-1:0]      input_real_a,
  input  logic [LANES-1:0][IN_W-1:0]      input_imag_a,
  input  logic [LANES-1:0][IN_W-1:0]      input_real_b,
  input  logic [LANES-1:0][IN_W-1:0]      input_imag_b,
  output logic                            valid_out,
  output logic [LANES-1:0][OUT_W-1:0]     output_real_a,
  output logic [LANES-1:0][OUT_W-1:0]     output_imag_a,
  output logic [LANES-1:0][OUT_W-1:0]     output_real_b,
  output logic [LANES-1:0][OUT_W-1:0]     output_imag_b
);

  localparam int S_W = IN_W + 1;

  logic [LANES-1:0][S_W-1:0]   sum_re_d, sum_im_d, dif_re_d, dif_im_d;
  logic [LANES-1:0][S_W-1:0]   sum_re_q, sum_im_q, dif_re_q, dif_im_q;
  logic [LANES-1:0]            rot_d, rot_q;
  logic                        v1_q, v2_q;
  logic [LANES-1:0][OUT_W-1:0] out_ra_d, out_ia_d, out_rb_d, out_ib_d;
  logic [LANES-1:0][OUT_W-1:0] out_ra_q, out_ia_q, out_rb_q, out_ib_q;

  function automatic logic [S_W-1:0] sx_in(input logic [IN_W-1:0] x);
    return {x[IN_W-1], x};
  endfunction

  function automatic logic [OUT_W-1:0] sx_out(input logic [S_W-1:0] x);
    return {{(OUT_W-S_W){x[S_W-1]}}, x};
  endfunction

  // Rotate flag is bit 7 of the wrapped 9-bit lane index, i.e. the second half of each 256 block.
  always_comb begin
    sum_re_d = '0;
    sum_im_d = '0;
    dif_re_d = '0;
    dif_im_d = '0;
    rot_d    = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_re_d[i] = sx_in(input_real_a[i]) + sx_in(input_real_b[i]);
      sum_im_d[i] = sx_in(input_imag_a[i]) + sx_in(input_imag_b[i]);
      dif_re_d[i] = sx_in(input_real_a[i]) - sx_in(input_real_b[i]);
      dif_im_d[i] = sx_in(input_imag_a[i]) - sx_in(input_imag_b[i]);
      rot_d[i]    = 1'((base_input_idx + IDX_W'(i)) >> (IDX_W - 2));
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      v1_q     <= 1'b0;
      sum_re_q <= '0;
      sum_im_q <= '0;
      dif_re_q <= '0;
      dif_im_q <= '0;
      rot_q    <= '0;
    end else begin
      v1_q <= valid_in;
      if (valid_in) begin
        sum_re_q <= sum_re_d;
        sum_im_q <= sum_im_d;
        dif_re_q <= dif_re_d;
        dif_im_q <= dif_im_d;
        rot_q    <= rot_d;
      end
    end
  end

  // Multiplying by -j swaps components and negates the new imaginary part.
  always_comb begin
    out_ra_d = '0;
    out_ia_d = '0;
    out_rb_d = '0;
    out_ib_d = '0;
    for (int i = 0; i < LANES; i++) begin
      out_ra_d[i] = sx_out(sum_re_q[i]);
      out_ia_d[i] = sx_out(sum_im_q[i]);
      out_rb_d[i] = rot_q[i] ? sx_out(dif_im_q[i]) : sx_out(dif_re_q[i]);
      out_ib_d[i] = rot_q[i] ? -sx_out(dif_re_q[i]) : sx_out(dif_im_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      v2_q     <= 1'b0;
      out_ra_q <= '0;
      out_ia_q <= '0;
      out_rb_q <= '0;
      out_ib_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        out_ra_q <= out_ra_d;
        out_ia_q <= out_ia_d;
        out_rb_q <= out_rb_d;
        out_ib_q <= out_ib_d;
      end
    end
  end

  assign valid_out     = v2_q;
  assign output_real_a = out_ra_q;
  assign output_imag_a = out_ia_q;
  assign output_real_b = out_rb_q;
  assign output_imag_b = out_ib_q;

endmodule

// File: tb/tb_fft_butterfly01.sv
// tb/tb_fft_butterfly01.sv - self-checking bench for fft_butterfly01
// Reference model works on plain integers and a queue of expected beats tagged with their due edge.
module tb_fft_butterfly01;

  localparam int LANES = 16;
  localparam int IN_W  = 10;
  localparam int OUT_W = 13;
  localparam int IDX_W = 9;

  logic                        clk;
  logic                        rstn;
  logic                        valid_in;
  logic [IDX_W-1:0]            base_input_idx;
  logic [LANES-1:0][IN_W-1:0]  input_real_a, input_imag_a, input_real_b, input_imag_b;
  logic                        valid_out;
  logic [LANES-1:0][OUT_W-1:0] output_real_a, output_imag_a, output_real_b, output_imag_b;

  fft_butterfly01 #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .valid_in      (valid_in),
    .base_input_idx(base_input_idx),
    .input_real_a  (input_real_a),
    .input_imag_a  (input_imag_a),
    .input_real_b  (input_real_b),
    .input_imag_b  (input_imag_b),
    .valid_out     (valid_out),
    .output_real_a (output_real_a),
    .output_imag_a (output_imag_a),
    .output_real_b (output_real_b),
    .output_imag_b (output_imag_b)
  );

  typedef struct {
    int                          due;
    logic [LANES-1:0][OUT_W-1:0] ra, ia, rb, ib;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   ar[LANES], ai[LANES], br[LANES], bi[LANES];
  int   cur_idx;
  int   edge_n;
  int   n_assert;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [255:0] obs, input logic [255:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int idx, input int due);
    exp_t e;
    int n, dr, di;
    bit rot;
    e.due = due;
    for (int i = 0; i < LANES; i++) begin
      n   = (idx + i) % 512;
      rot = (n % 256) >= 128;
      dr  = ar[i] - br[i];
      di  = ai[i] - bi[i];
      e.ra[i] = OUT_W'(ar[i] + br[i]);
      e.ia[i] = OUT_W'(ai[i] + bi[i]);
      e.rb[i] = OUT_W'(rot ? di : dr);
      e.ib[i] = OUT_W'(rot ? -dr : di);
    end
    return e;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < LANES; i++) begin
      input_real_a[i] = IN_W'(ar[i]);
      input_imag_a[i] = IN_W'(ai[i]);
      input_real_b[i] = IN_W'(br[i]);
      input_imag_b[i] = IN_W'(bi[i]);
    end
    base_input_idx = IDX_W'(cur_idx);
  endtask

  // One clock edge: update the scoreboard, then sample outputs 1 time unit later.
  task automatic step();
    bit exp_v;
    @(posedge clk);
    edge_n++;
    if (rstn) begin
      q.delete();
      last.ra = '0; last.ia = '0; last.rb = '0; last.ib = '0;
    end else if (valid_in) begin
      q.push_back(model(cur_idx, edge_n + 1));
    end
    #1;
    exp_v = (q.size() > 0) && (q[0].due == edge_n);
    if (exp_v) last = q.pop_front();
    chk(256'(valid_out), 256'(exp_v), "valid_out");
    chk(256'(output_real_a), 256'(last.ra), "out_real_a");
    chk(256'(output_imag_a), 256'(last.ia), "out_imag_a");
    chk(256'(output_real_b), 256'(last.rb), "out_real_b");
    chk(256'(output_imag_b), 256'(last.ib), "out_imag_b");
  endtask

  task automatic beat(input int idx);
    cur_idx  = idx;
    drive_data();
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_const(input int a_re, input int a_im, input int b_re, input int b_im);
    for (int i = 0; i < LANES; i++) begin
      ar[i] = a_re; ai[i] = a_im; br[i] = b_re; bi[i] = b_im;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < LANES; i++) begin
      ar[i] = int'($urandom_range(1023)) - 512;
      ai[i] = int'($urandom_range(1023)) - 512;
      br[i] = int'($urandom_range(1023)) - 512;
      bi[i] = int'($urandom_range(1023)) - 512;
    end
  endtask

  // Hand-derived values on one lane, independent of the model.
  task automatic lit(input int lane, input int ra, input int ia, input int rb, input int ib,
                     input string tag);
    logic [OUT_W-1:0] e;
    e = OUT_W'(ra); chk(256'(output_real_a[lane]), 256'(e), {tag, "_ra"});
    e = OUT_W'(ia); chk(256'(output_imag_a[lane]), 256'(e), {tag, "_ia"});
    e = OUT_W'(rb); chk(256'(output_real_b[lane]), 256'(e), {tag, "_rb"});
    e = OUT_W'(ib); chk(256'(output_imag_b[lane]), 256'(e), {tag, "_ib"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    edge_n   = 0;
    cur_idx  = 0;
    last.due = 0;
    last.ra = '0; last.ia = '0; last.rb = '0; last.ib = '0;
    rstn     = 1'b1;
    valid_in = 1'b1;
    set_const(100, -50, 30, 20);
    drive_data();

    // T1: reset held with valid_in high
    step();
    step();
    rstn = 1'b0;
    idle(3);

    // T2: idx 0, not rotated
    set_const(100, -50, 30, 20);
    beat(0);
    idle(1);
    lit(0, 130, -30, 70, -70, "t2");
    idle(1);

    // T3: rotated / not rotated indices
    beat(128);
    idle(1);
    lit(5, 130, -30, -70, -70, "t3_128");
    beat(240);
    idle(1);
    lit(15, 130, -30, -70, -70, "t3_240");
    beat(256);
    idle(1);
    lit(3, 130, -30, 70, -70, "t3_256");

    // T4: extremes
    set_const(511, 511, -512, -512);
    beat(0);
    idle(1);
    lit(0, -1, -1, 1023, 1023, "t4_0");
    beat(384);
    idle(1);
    lit(15, -1, -1, 1023, -1023, "t4_384");
    idle(1);

    // T5: 32 back-to-back beats with ramp data
    for (int k = 0; k < 32; k++) begin
      for (int i = 0; i < LANES; i++) begin
        ar[i] = k * 16 + i - 256;
        ai[i] = 255 - (k * 16 + i);
        br[i] = ((k * 16 + i) * 3) % 1024 - 512;
        bi[i] = (k * 7 + i * 13) % 1024 - 512;
      end
      cur_idx  = k * 16;
      drive_data();
      valid_in = 1'b1;
      step();
    end
    idle(3);

    // T6: reset right after an accepted beat drops it
    set_rand();
    beat(128);
    rstn = 1'b1;
    step();
    rstn = 1'b0;
    idle(3);
    set_rand();
    beat(400);
    idle(3);

    // Random beats with random gaps and indices
    for (int k = 0; k < 60; k++) begin
      set_rand();
      cur_idx  = int'($urandom_range(31)) * 16;
      drive_data();
      valid_in = ($urandom_range(9) < 7);
      step();
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
